layered_color_mapper: RTL

- Pipelined, parametrised successor to the single-layer background color mapper.
- Composites a vertically scrolling, pixel-doubled background bitmap with NUM_SPRITES sprite layers (e.g. player car, rival cars). Each layer has its own writable palette and a transparency key.
- Drives RGB to the VGA/HDMI output stage with a fixed 3-cycle latency.
- Reports sprite-to-sprite collisions to game logic as a per-frame sticky flag.

---
 rtl/layered_color_mapper.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/layered_color_mapper.sv
// layered_color_mapper: 3-stage background + sprite compositor with palettes and collision flag
module layered_color_mapper #(
    parameter int BG_W        = 320,
    parameter int BG_H        = 240,
    parameter int SCALE_SH    = 1,
    parameter int NUM_SPRITES = 2,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int IDX_W       = 3,
    parameter int TRANSP      = 0
) (
    input  logic                                        Clk,
    input  logic                                        Reset,
    input  logic [9:0]                                  DrawX,
    input  logic [9:0]                                  DrawY,
    input  logic                                        pixel_valid,
    input  logic                                        frame_start,
    input  logic [8:0]                                  scroll_y,
    input  logic [10*NUM_SPRITES-1:0]                   spr_x,
    input  logic [10*NUM_SPRITES-1:0]                   spr_y,
    input  logic [NUM_SPRITES-1:0]                      spr_en,
    output logic [$clog2(BG_W*BG_H)-1:0]                bg_addr,
    input  logic [IDX_W-1:0]                            bg_idx,
    output logic [NUM_SPRITES*$clog2(SPR_W*SPR_H)-1:0]  spr_addr,
    input  logic [NUM_SPRITES*IDX_W-1:0]                spr_idx,
    input  logic                                        pal_we,
    input  logic [2:0]                                  pal_sel,
    input  logic [IDX_W-1:0]                            pal_addr,
    input  logic [23:0]                                 pal_data,
    output logic [7:0]                                  Red,
    output logic [7:0]                                  Green,
    output logic [7:0]                                  Blue,
    output logic                                        out_valid,
    output logic                                        collision
);
    localparam int BA_W = $clog2(BG_W*BG_H);
    localparam int SA_W = $clog2(SPR_W*SPR_H);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam int PE = 1 << IDX_W;
    localparam logic [9:0] BW10 = 10'(BG_W);
    localparam logic [9:0] BH10 = 10'(BG_H);
    localparam logic [8:0] BH9 = 9'(BG_H);
    localparam logic [9:0] SW10 = 10'(SPR_W);
    localparam logic [9:0] SH10 = 10'(SPR_H);
    localparam logic [IDX_W-1:0] TI = IDX_W'(TRANSP);

    logic [8:0] scroll;
    logic [9:0] sx [NUM_SPRITES];
    logic [9:0] sy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sen;
    logic [23:0] bg_pal [PE];
    logic [23:0] spr_pal [NUM_SPRITES][PE];

    logic [9:0] tx, ty, row, rw;
    logic [9:0] dx [NUM_SPRITES];
    logic [9:0] dy [NUM_SPRITES];
    logic bg_in_c;
    logic [BA_W-1:0] bg_addr_c;
    logic [NUM_SPRITES-1:0] hit_c;
    logic [SA_W-1:0] saddr_c [NUM_SPRITES];

    logic v1, bgin1, v2, bgin2;
    logic [NUM_SPRITES-1:0] hit1, hit2;
    logic [IDX_W-1:0] bgidx2;
    logic [NUM_SPRITES*IDX_W-1:0] sidx2;

    logic [NUM_SPRITES-1:0] op_c;
    logic [2:0] n_op;
    logic [23:0] color_c;

    // frame-constant scroll and sprite placement, captured on frame_start
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scroll <= '0;
            sen <= '0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                sx[k] <= '0;
                sy[k] <= '0;
            end
        end else if (frame_start) begin
            if (scroll_y < BH9) scroll <= scroll_y;
            sen <= spr_en;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                sx[k] <= spr_x[k*10 +: 10];
                sy[k] <= spr_y[k*10 +: 10];
            end
        end
    end

    // palette RAMs; pal_sel beyond the last sprite writes nothing
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < PE; i++) begin
                bg_pal[i] <= '0;
                for (int k = 0; k < NUM_SPRITES; k++) spr_pal[k][i] <= '0;
            end
        end else if (pal_we) begin
            if (pal_sel == 3'd0) bg_pal[pal_addr] <= pal_data;
            for (int k = 0; k < NUM_SPRITES; k++)
                if (pal_sel == 3'(k + 1)) spr_pal[k][pal_addr] <= pal_data;
        end
    end

    // stage 1 address generation: scrolled background texel and sprite-local offsets
    always_comb begin
        tx = DrawX >> SCALE_SH;
        ty = DrawY >> SCALE_SH;
        bg_in_c = pixel_valid && tx < BW10 && ty < BH10;
        row = ty + {1'b0, scroll};
        rw = row >= BH10 ? row - BH10 : row;
        bg_addr_c = bg_in_c ? BA_W'(rw) * BA_W'(BG_W) + BA_W'(tx) : '0;
        hit_c = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            dx[k] = DrawX - sx[k];
            dy[k] = DrawY - sy[k];
            hit_c[k] = sen[k] && pixel_valid && dx[k] < SW10 && dy[k] < SH10;
            saddr_c[k] = hit_c[k] ? {dy[k][YW-1:0], dx[k][XW-1:0]} : '0;
        end
    end

    // stage 1 and 2 pipeline registers; ROM data is captured in stage 2
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bg_addr <= '0;
            spr_addr <= '0;
            v1 <= 1'b0;
            bgin1 <= 1'b0;
            hit1 <= '0;
            v2 <= 1'b0;
            bgin2 <= 1'b0;
            hit2 <= '0;
            bgidx2 <= '0;
            sidx2 <= '0;
        end else begin
            bg_addr <= bg_addr_c;
            for (int k = 0; k < NUM_SPRITES; k++) spr_addr[k*SA_W +: SA_W] <= saddr_c[k];
            v1 <= pixel_valid;
            bgin1 <= bg_in_c;
            hit1 <= hit_c;
            v2 <= v1;
            bgin2 <= bgin1;
            hit2 <= hit1;
            bgidx2 <= bg_idx;
            sidx2 <= spr_idx;
        end
    end

    // stage 3 priority: scan from lowest priority upward so sprite 0 wins
    always_comb begin
        op_c = '0;
        n_op = '0;
        color_c = bgin2 ? bg_pal[bgidx2] : 24'h000000;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            op_c[k] = hit2[k] && sidx2[k*IDX_W +: IDX_W] != TI;
            if (op_c[k]) color_c = spr_pal[k][sidx2[k*IDX_W +: IDX_W]];
            n_op = n_op + 3'(op_c[k]);
        end
    end

    // stage 3 output register and sticky collision (set beats frame_start clear)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Red <= '0;
            Green <= '0;
            Blue <= '0;
            out_valid <= 1'b0;
            collision <= 1'b0;
        end else begin
            Red <= v2 ? color_c[23:16] : 8'h00;
            Green <= v2 ? color_c[15:8] : 8'h00;
            Blue <= v2 ? color_c[7:0] : 8'h00;
            out_valid <= v2;
            collision <= (v2 && n_op >= 3'd2) || (collision && !frame_start);
        end
    end
endmodule
